// File: rtl/pixel_pkg.sv
// pixel_pkg
//   Constants and types shared by the pixel pipeline: scanner, iteration
//   engine and packer.
//   X_SIZE/Y_SIZE  raster geometry
//   COORD_W        signed coordinate width (Q4.21)
//   FRAC_BITS      fractional bits of a coordinate
//   BASE_SHIFT     pixel pitch at zoom 0 is 2^-BASE_SHIFT
package pixel_pkg;

    localparam int X_SIZE     = 640;
    localparam int Y_SIZE     = 480;
    localparam int COORD_W    = 25;
    localparam int FRAC_BITS  = 21;
    localparam int BASE_SHIFT = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } scan_state_t;

endpackage

// File: rtl/coord_scanner.sv
// coord_scanner
//   Walks the raster in row-major order and emits one complex coordinate per
//   accepted beat, with raster position and frame/line markers.
//   Zoom and offsets are captured once per frame in LOAD, so changes made
//   while a frame is running only show up in the next frame.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   enable            start/continue frame generation (checked at frame end)
//   zoom              pitch = 2^-(BASE_SHIFT+zoom)
//   x_offset/y_offset signed centre of the frame
//   ready/valid       AXI-Stream style handshake
//   c_re, c_im        signed Q4.21 coordinate of the current pixel
//   x, y              pixel column / row
//   first/last_x/last_y  markers, meaningful only while valid=1
// H_PIXELS/V_LINES default to the pipeline geometry; they exist so a reduced
// raster can be elaborated.
module coord_scanner
    import pixel_pkg::*;
#(
    parameter int H_PIXELS = X_SIZE,
    parameter int V_LINES  = Y_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [2:0]                zoom,
    input  logic signed [COORD_W-1:0] x_offset,
    input  logic signed [COORD_W-1:0] y_offset,
    input  logic                      ready,
    output logic                      valid,
    output logic signed [COORD_W-1:0] c_re,
    output logic signed [COORD_W-1:0] c_im,
    output logic [9:0]                x,
    output logic [8:0]                y,
    output logic                      first,
    output logic                      last_x,
    output logic                      last_y
);

    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST = 9'(V_LINES - 1);
    localparam logic signed [COORD_W-1:0] HALF_W = COORD_W'(H_PIXELS / 2);
    localparam logic signed [COORD_W-1:0] HALF_H = COORD_W'(V_LINES / 2);
    localparam logic [4:0] BASE_EXP = 5'(FRAC_BITS - BASE_SHIFT);

    scan_state_t state;

    // Per-frame registers captured in LOAD.
    logic signed [COORD_W-1:0] step;
    logic signed [COORD_W-1:0] re_start;

    // Frame parameters derived from the live inputs. The step is a power of
    // two, so the half-width/half-height offsets are plain shifts.
    logic [4:0]                shamt;
    logic signed [COORD_W-1:0] load_step;
    logic signed [COORD_W-1:0] load_re;
    logic signed [COORD_W-1:0] load_im;

    always_comb begin
        shamt     = BASE_EXP - 5'(zoom);
        load_step = COORD_W'(1) << shamt;
        load_re   = x_offset - (HALF_W << shamt);
        load_im   = y_offset + (HALF_H << shamt);
    end

    // Markers gated by valid so they read 0 in reset and between frames.
    assign first  = valid && (x == '0) && (y == '0);
    assign last_x = valid && (x == X_LAST);
    assign last_y = valid && (y == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= 1'b0;
            x        <= '0;
            y        <= '0;
            c_re     <= '0;
            c_im     <= '0;
            step     <= '0;
            re_start <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (enable) state <= LOAD;
                end
                LOAD: begin
                    step     <= load_step;
                    re_start <= load_re;
                    c_re     <= load_re;
                    c_im     <= load_im;
                    x        <= '0;
                    y        <= '0;
                    valid    <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (!valid || ready) begin
                        if (last_x && last_y) begin
                            // Frame done; enable only matters here.
                            valid <= 1'b0;
                            state <= enable ? LOAD : IDLE;
                        end else if (last_x) begin
                            x    <= '0;
                            y    <= y + 9'd1;
                            c_re <= re_start;
                            c_im <= c_im - step;
                        end else begin
                            x    <= x + 10'd1;
                            c_re <= c_re + step;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
